// File: rtl/pg_alu_pkg.sv
// Shared definitions for the power-gated multi-cycle ALU: opcodes, FSM
// states, flag bit positions and a helper that packs the flag vector.
package pg_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DBZ   = 3;

    function automatic logic [3:0] make_flags(input logic dbz, input logic ovf,
                                              input logic carry, input logic zero);
        logic [3:0] f;
        f            = '0;
        f[FLG_DBZ]   = dbz;
        f[FLG_OVF]   = ovf;
        f[FLG_CARRY] = carry;
        f[FLG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/pg_alu_div.sv
// Unsigned restoring divider, one quotient bit per cycle. The dividend is
// shifted out of r_quo MSB-first while quotient bits shift in at the bottom.
// o_done is asserted during the cycle of the final iteration and the
// quotient/remainder outputs then show the post-iteration values, so the
// parent can capture them on the same edge. A zero divisor skips the loop
// and reports all-ones quotient, remainder = dividend, one cycle after start.
module pg_alu_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_dbz
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_dbz;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    assign o_done      = r_dbz | (r_busy & (r_cnt == CW'(WIDTH - 1)));
    assign o_quotient  = r_dbz ? '1 : w_quo_next;
    assign o_remainder = r_dbz ? r_quo : w_rem_next;
    assign o_dbz       = r_dbz;

    // Load operands on start, then iterate one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (i_start) begin
            r_quo  <= i_a;
            r_div  <= i_b;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= (i_b != '0);
            r_dbz  <= (i_b == '0);
        end else if (r_dbz) begin
            r_dbz  <= 1'b0;
        end else if (r_busy) begin
            r_quo  <= w_quo_next;
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pg_mc_alu.sv
// Power-gated multi-cycle ALU. Valid/ready accept, single-cycle logic and
// arithmetic ops, counted-latency multiply, iterative divide. Losing power
// or asserting isolation kills any operation and returns to IDLE; isolation
// additionally clamps every output to 0. WIDTH must be a power of two >= 4
// and MUL_LAT >= 1.
//
//   state | meaning
//   IDLE  | waiting for an operation, in_ready when powered and not isolated
//   MUL   | multiply latency counter running 1..MUL_LAT
//   DIV   | divider iterating (or reporting divide-by-zero)
//   DONE  | result held with out_valid until out_ready
module pg_mc_alu
    import pg_alu_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int MUL_LAT = 4,
    localparam int SHW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_pwr_en,
    input  logic             iso_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic             aborted
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic [3:0]       r_flags;
    logic             r_illegal;
    logic             r_aborted;

    logic             w_kill;
    logic             w_ready;
    logic             w_accept;
    logic             w_mul_last;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_carry;
    logic             w_sc_ovf;
    logic             w_sc_illegal;
    logic [2*WIDTH-1:0] w_prod;

    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;
    logic             w_div_dbz;

    assign w_kill     = ~alu_pwr_en | iso_en;
    assign w_ready    = (r_state == S_IDLE) & ~w_kill;
    assign w_accept   = in_valid & w_ready;
    assign w_mul_last = (r_state == S_MUL) & (r_cnt == CW'(MUL_LAT));
    assign w_sh       = B[SHW-1:0];
    assign w_sum      = {1'b0, A} + {1'b0, B};
    assign w_diff     = {1'b0, A} - {1'b0, B};
    assign w_prod     = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    pg_alu_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk         (clk),
        .i_clr       (rst | w_kill),
        .i_start     (w_accept & (opcode == OP_DIV)),
        .i_a         (A),
        .i_b         (B),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_dbz       (w_div_dbz)
    );

    // Single-cycle ops evaluate straight from the inputs at accept.
    always_comb begin
        w_sc_res     = '0;
        w_sc_carry   = 1'b0;
        w_sc_ovf     = 1'b0;
        w_sc_illegal = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_sc_res   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
                w_sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res   = w_diff[WIDTH-1:0];
                w_sc_carry = w_diff[WIDTH];
                w_sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_sc_res = A & B;
            OP_OR:   w_sc_res = A | B;
            OP_XOR:  w_sc_res = A ^ B;
            OP_NOR:  w_sc_res = ~(A | B);
            OP_SHL:  w_sc_res = A << w_sh;
            OP_XNOR: w_sc_res = ~(A ^ B);
            OP_MUL:  w_sc_res = '0;
            OP_DIV:  w_sc_res = '0;
            OP_SHR:  w_sc_res = A >> w_sh;
            OP_SRA:  w_sc_res = $signed(A) >>> w_sh;
            default: w_sc_illegal = 1'b1;
        endcase
    end

    // Next-state decode; power loss or isolation overrides everything.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (opcode == OP_MUL) begin
                        w_next_state = S_MUL;
                    end else if (opcode == OP_DIV) begin
                        w_next_state = S_DIV;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_MUL:   if (w_mul_last) w_next_state = S_DONE;
            S_DIV:   if (w_div_done) w_next_state = S_DONE;
            S_DONE:  if (out_ready)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_kill) begin
            w_next_state = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latches, multiply counter and result registers.
    always_ff @(posedge clk) begin
        if (rst || w_kill) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_illegal   <= 1'b0;
            r_aborted   <= ~rst & (r_state != S_IDLE);
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a <= A;
                        r_b <= B;
                        if (opcode == OP_MUL) begin
                            r_cnt <= CW'(1);
                        end else if (opcode != OP_DIV) begin
                            r_result    <= w_sc_res;
                            r_result_hi <= '0;
                            r_flags     <= make_flags(1'b0, w_sc_ovf, w_sc_carry,
                                                      w_sc_res == '0);
                            r_illegal   <= w_sc_illegal;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_cnt       <= '0;
                        r_result    <= w_prod[WIDTH-1:0];
                        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_flags     <= make_flags(1'b0, 1'b0, 1'b0,
                                                  w_prod[WIDTH-1:0] == '0);
                        r_illegal   <= 1'b0;
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        r_result    <= w_div_quo;
                        r_result_hi <= w_div_rem;
                        r_flags     <= make_flags(w_div_dbz, 1'b0, 1'b0,
                                                  w_div_quo == '0);
                        r_illegal   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = (r_state == S_DONE) & ~iso_en;
    assign result    = iso_en ? '0 : r_result;
    assign result_hi = iso_en ? '0 : r_result_hi;
    assign flags     = iso_en ? '0 : r_flags;
    assign illegal   = r_illegal & ~iso_en;
    assign aborted   = r_aborted & ~iso_en;

endmodule

// File: tb/tb_pg_mc_alu.sv
// Directed bench for pg_mc_alu at WIDTH=16, MUL_LAT=4.
module tb_pg_mc_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_pwr_en;
    logic        iso_en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [3:0]  flags;
    logic        illegal;
    logic        aborted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pg_mc_alu #(
        .WIDTH   (16),
        .MUL_LAT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .flags      (flags),
        .illegal    (illegal),
        .aborted    (aborted)
    );

    // Offer one op, scramble operands after accept, count edges to out_valid.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        @(negedge clk);
        opcode = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; opcode = 4'd0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_op;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_pwr_en = 1'b1; iso_en = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; opcode = 4'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, result_hi, flags, illegal, aborted} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b r=%h hi=%h f=%b i=%b a=%b want all 0",
                     out_valid, result, result_hi, flags, illegal, aborted);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub;
        int lat;
        run_op(4'd0, 16'hFFFF, 16'h0001, lat);
        n_cmp++;
        if (lat !== 1 || {result, result_hi, flags, illegal} !== {16'h0000, 16'h0000, 4'b0011, 1'b0}) begin
            n_err++;
            $display("FAIL add_wrap got lat=%0d r=%h hi=%h f=%b i=%b want lat=1 r=0000 hi=0000 f=0011 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
        run_op(4'd1, 16'h8000, 16'h0001, lat);
        n_cmp++;
        if (lat !== 1 || {result, result_hi, flags, illegal} !== {16'h7FFF, 16'h0000, 4'b0100, 1'b0}) begin
            n_err++;
            $display("FAIL sub_ovf got lat=%0d r=%h hi=%h f=%b i=%b want lat=1 r=7fff hi=0000 f=0100 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
    endtask

    task automatic test_mul;
        int lat;
        run_op(4'd8, 16'h1234, 16'h5678, lat);
        n_cmp++;
        if (lat !== 5 || {result, result_hi, flags, illegal} !== {16'h0060, 16'h0626, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL mul got lat=%0d r=%h hi=%h f=%b i=%b want lat=5 r=0060 hi=0626 f=0000 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
    endtask

    task automatic test_div;
        int lat;
        run_op(4'd9, 16'd1000, 16'd7, lat);
        n_cmp++;
        if (lat !== 17 || {result, result_hi, flags, illegal} !== {16'd142, 16'd6, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL div got lat=%0d q=%0d r=%0d f=%b i=%b want lat=17 q=142 r=6 f=0000 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
        run_op(4'd9, 16'd5, 16'd0, lat);
        n_cmp++;
        if (lat !== 2 || {result, result_hi, flags, illegal} !== {16'hFFFF, 16'h0005, 4'b1000, 1'b0}) begin
            n_err++;
            $display("FAIL div_by_zero got lat=%0d q=%h r=%h f=%b i=%b want lat=2 q=ffff r=0005 f=1000 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
    endtask

    task automatic test_shift_illegal;
        int lat;
        run_op(4'd11, 16'h8000, 16'h0013, lat);
        n_cmp++;
        if (lat !== 1 || {result, result_hi, flags, illegal} !== {16'hF000, 16'h0000, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL sra got lat=%0d r=%h hi=%h f=%b i=%b want lat=1 r=f000 hi=0000 f=0000 i=0",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
        run_op(4'd13, 16'h1234, 16'h5678, lat);
        n_cmp++;
        if (lat !== 1 || {result, result_hi, flags, illegal} !== {16'h0000, 16'h0000, 4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL illegal_op got lat=%0d r=%h hi=%h f=%b i=%b want lat=1 r=0000 hi=0000 f=0001 i=1",
                     lat, result, result_hi, flags, illegal);
        end
        release_op();
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops  [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd6, 4'd10, 4'd0, 4'd1, 4'd1};
        logic [15:0] va   [10] = '{16'hF0F0, 16'hF0F0, 16'h5555, 16'h0000, 16'h1234,
                                   16'h0001, 16'h8000, 16'h7FFF, 16'h0003, 16'h1234};
        logic [15:0] vb   [10] = '{16'h0FF0, 16'h0FF0, 16'hFFFF, 16'h0000, 16'h1234,
                                   16'h0014, 16'h000F, 16'h0001, 16'h0005, 16'h1234};
        logic [15:0] eres [10] = '{16'h00F0, 16'hFFF0, 16'hAAAA, 16'hFFFF, 16'hFFFF,
                                   16'h0010, 16'h0001, 16'h8000, 16'hFFFE, 16'h0000};
        logic [3:0]  eflg [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0000, 4'b0100, 4'b0010, 4'b0001};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            end
            opcode = ops[i]; A = va[i]; B = vb[i]; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, eres[i], eflg[i]}) begin
                n_err++;
                $display("FAIL b2b_op[%0d] got v=%b rdy=%b r=%h f=%b want v=1 rdy=0 r=%h f=%b",
                         i, out_valid, in_ready, result, flags, eres[i], eflg[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_abort_div;
        int seen;
        @(negedge clk);
        opcode = 4'd9; A = 16'd1000; B = 16'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        alu_pwr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({aborted, out_valid, in_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_pulse got ab=%b v=%b rdy=%b want ab=1 v=0 rdy=0",
                     aborted, out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (aborted !== 1'b0) begin
            n_err++;
            $display("FAIL abort_one_cycle got %b want 0", aborted);
        end
        alu_pwr_en = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready_back got %b want 1", in_ready);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_result got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_iso_done;
        int lat;
        run_op(4'd0, 16'h0003, 16'h0004, lat);
        n_cmp++;
        if (lat !== 1 || result !== 16'h0007) begin
            n_err++;
            $display("FAIL iso_pre got lat=%0d r=%h want lat=1 r=0007", lat, result);
        end
        iso_en = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result, result_hi, flags, illegal, aborted} !== 40'd0) begin
            n_err++;
            $display("FAIL iso_clamp got rdy=%b v=%b r=%h hi=%h f=%b i=%b ab=%b want all 0",
                     in_ready, out_valid, result, result_hi, flags, illegal, aborted);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({aborted, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL iso_abort_clamped got ab=%b v=%b want 0 0", aborted, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        iso_en = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result, flags, aborted} !== {1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL iso_after got rdy=%b v=%b r=%h f=%b ab=%b want rdy=1 v=0 r=0000 f=0000 ab=0",
                     in_ready, out_valid, result, flags, aborted);
        end
    endtask

    task automatic test_rst_mid_mul;
        int seen;
        @(negedge clk);
        opcode = 4'd8; A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, result_hi, flags, illegal, aborted} !== 39'd0) begin
            n_err++;
            $display("FAIL rst_mid_mul got v=%b r=%h hi=%h f=%b i=%b ab=%b want all 0",
                     out_valid, result, result_hi, flags, illegal, aborted);
        end
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid || aborted) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_mid_mul_quiet got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_hold;
        int lat;
        run_op(4'd8, 16'h1234, 16'h5678, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL hold_lat got %0d want 5", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, result_hi, result} !== {1'b1, 1'b0, 16'h0626, 16'h0060}) begin
                n_err++;
                $display("FAIL hold[%0d] got v=%b rdy=%b hi=%h r=%h want v=1 rdy=0 hi=0626 r=0060",
                         i, out_valid, in_ready, result_hi, result);
            end
        end
        release_op();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift_illegal();
        test_back_to_back();
        test_abort_div();
        test_iso_done();
        test_rst_mid_mul();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
